l1_mem_req_ctrl: RTL and testbench
==================================

Name: l1_mem_req_ctrl

Overview:
- Initiator-side controller for the self-initialising single-port L1 memory wrapper.
- Accepts read/write requests from the L1 pipeline on a valid/ready channel.
- Waits for the memory's init-done `ready` before driving EN/WE/ADDR/WDATA.
- Returns read data in order on a valid/ready response channel, with a one-entry hold register so response back-pressure never loses SRAM data.

Parameters:
- WIDTH, 32, data width; must match the memory wrapper.
- DEPTH, 1024, memory depth in words; address width AW = $clog2(DEPTH).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- REQ_VAL  in  1  request valid.
- REQ_RDY  out  1  request accepted when REQ_VAL & REQ_RDY.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  AW  word address.
- REQ_WDATA  in  WIDTH  write data.
- RSP_VAL  out  1  read response valid.
- RSP_RDY  in  1  response consumer ready.
- RSP_RDATA  out  WIDTH  read data.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  WIDTH  memory write data.
- MEM_RDATA  in  WIDTH  memory read data; valid the cycle after a read enable.
- MEM_READY  in  1  memory init done.

Behaviour:
- Reset (RST=1, asynchronous):
  - state = INIT; rd_pend_r = 0; hold_val_r = 0; hold_data_r = 0.
  - Outputs: REQ_RDY=0, RSP_VAL=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, RSP_RDATA=0.
  - Reset mid-operation drops any pending read or held response without emitting it.
- FSM, two states:
  - INIT -> RUN on the first clock edge with MEM_READY=1.
  - RUN -> INIT if MEM_READY falls. A response already pending or held is still delivered; no new requests are accepted.
- stall = hold_val_r | (rd_pend_r & ~RSP_RDY).
- REQ_RDY = (state==RUN) & ~stall. This is combinational from RSP_RDY.
- Accept (REQ_VAL & REQ_RDY), same cycle:
  - MEM_EN=1, MEM_WE=REQ_WE, MEM_ADDR=REQ_ADDR, MEM_WDATA=REQ_WDATA.
  - Otherwise MEM_EN=0, MEM_WE=0, and MEM_ADDR/MEM_WDATA are 0.
- Writes: single cycle, produce no response.
- Reads:
  - rd_pend_r <= 1 on an accepted read, else 0.
  - Latency is 1 cycle: response visible the cycle after acceptance.
- Response path:
  - RSP_VAL = rd_pend_r | hold_val_r.
  - RSP_RDATA = hold_val_r ? hold_data_r : (rd_pend_r ? MEM_RDATA : 0).
- Hold register:
  - If rd_pend_r & ~RSP_RDY: hold_data_r <= MEM_RDATA, hold_val_r <= 1.
  - hold_val_r clears on RSP_VAL & RSP_RDY.
  - While hold_val_r=1, REQ_RDY=0, so MEM_RDATA cannot be overwritten by a new read.
- Throughput:
  - Back-to-back reads at 1 per cycle while RSP_RDY=1.
  - Write followed by read of the same address on the next cycle returns the new data (SRAM ordering).
- Ordering: responses are strictly in request order; at most one read is in flight plus one held.
- Boundary cases:
  - Address DEPTH-1 is legal; no wrap or check inside the block.
  - REQ_VAL during INIT: no memory access, request stays pending upstream.
  - Simultaneous hold clear and new request: REQ_RDY stays 0 in that cycle (it uses registered hold_val_r); the new request is accepted the next cycle.

Test Plan:
1. Init gating: RST pulse, MEM_READY low 1024 cycles with REQ_VAL=1 -> REQ_RDY=0, MEM_EN=0 throughout; MEM_READY=1 -> REQ_RDY=1 the following cycle.
2. Write/read: write addr 0x005 data 0xDEADBEEF, next cycle read 0x005 -> RSP_VAL=1 one cycle later with RSP_RDATA=0xDEADBEEF; unwritten addr 0x3FF reads 0x00000000.
3. Streaming: 16 back-to-back reads, RSP_RDY=1 -> 16 responses on consecutive cycles, in order, REQ_RDY constantly 1.
4. Back-pressure: read 0x005 then drop RSP_RDY for 5 cycles -> RSP_VAL held 1, RSP_RDATA stable 0xDEADBEEF, REQ_RDY=0, MEM_EN=0; raise RSP_RDY -> single handshake, REQ_RDY returns 1 the next cycle.
5. Reset mid-op: assert RST while hold_val_r=1 -> RSP_VAL=0, REQ_RDY=0 immediately (asynchronous); no stale response after MEM_READY returns.
6. MEM_READY drop in RUN with a read pending -> response still delivered, REQ_RDY=0 until MEM_READY returns.

Source files
------------

// File: rtl/l1_mem_req_ctrl_if.sv
// Handshake bundles around the L1 memory request controller.
// l1_req_if: pipeline request/response channel (master = pipeline, slave = controller).
// l1_mem_if: SRAM port (master = controller, slave = memory wrapper).

interface l1_req_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
);
    logic             req_val;
    logic             req_rdy;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_val;
    logic             rsp_rdy;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_val, req_we, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_val, rsp_rdata
    );

    modport slave (
        input  req_val, req_we, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_val, rsp_rdata
    );
endinterface

interface l1_mem_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
);
    logic             en;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ready;

    modport master (
        output en, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  en, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/l1_mem_req_ctrl.sv
// Initiator-side controller for the self-initialising single-port L1 SRAM.
// Latency: writes single cycle, read data returned the cycle after acceptance.
// Backpressure: a one-entry hold register captures SRAM data when rsp_rdy is low;
// new requests are refused while a response is stalled or held.

module l1_mem_req_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic     clk,
    input  logic     rst,
    l1_req_if.slave  req,
    l1_mem_if.master mem
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rd_pend_r;
    logic             hold_val_r;
    logic [WIDTH-1:0] hold_data_r;
    logic             stall;
    logic             accept;

    // A response is stalled if one is already held, or if this cycle's SRAM data is refused.
    assign stall  = hold_val_r | (rd_pend_r & ~req.rsp_rdy);
    assign accept = req.req_val & req.req_rdy;

    // State register: memory init handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: run only while the memory reports its init as done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (mem.ready)  state_nxt = ST_RUN;
            ST_RUN:  if (!mem.ready) state_nxt = ST_INIT;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Outputs: SRAM drive on accept, response mux preferring the held word.
    always_comb begin
        req.req_rdy   = (state == ST_RUN) & ~stall;
        mem.en        = 1'b0;
        mem.we        = 1'b0;
        mem.addr      = '0;
        mem.wdata     = '0;
        if (accept) begin
            mem.en    = 1'b1;
            mem.we    = req.req_we;
            mem.addr  = req.req_addr[AW-1:0];
            mem.wdata = req.req_wdata;
        end
        req.rsp_val   = rd_pend_r | hold_val_r;
        if (hold_val_r) begin
            req.rsp_rdata = hold_data_r;
        end else if (rd_pend_r) begin
            req.rsp_rdata = mem.rdata;
        end else begin
            req.rsp_rdata = '0;
        end
    end

    // Read-in-flight flag: the SRAM data is valid exactly one cycle after a read enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= accept & ~req.req_we;
        end
    end

    // Hold register: park SRAM data when the consumer refuses it, release on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_val_r  <= 1'b0;
            hold_data_r <= '0;
        end else if (rd_pend_r & ~req.rsp_rdy) begin
            hold_val_r  <= 1'b1;
            hold_data_r <= mem.rdata;
        end else if (hold_val_r & req.rsp_rdy) begin
            hold_val_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l1_mem_req_ctrl.sv
// Directed bench for l1_mem_req_ctrl with a behavioural single-port SRAM model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.
// Each step compares outputs to hand-computed values with immediate assertions.

module tb_l1_mem_req_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    l1_req_if #(.WIDTH(WIDTH), .AW(AW)) req_bus ();
    l1_mem_if #(.WIDTH(WIDTH), .AW(AW)) mem_bus ();

    l1_mem_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus.slave),
        .mem (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: zero-initialised, read data valid the cycle after enable.
    logic [WIDTH-1:0] sram [DEPTH];
    logic [WIDTH-1:0] sram_rdata = '0;
    initial for (int k = 0; k < DEPTH; k++) sram[k] = '0;
    always @(posedge clk) begin
        if (mem_bus.en) begin
            if (mem_bus.we) sram[mem_bus.addr] <= mem_bus.wdata;
            else            sram_rdata <= sram[mem_bus.addr];
        end
    end
    assign mem_bus.rdata = sram_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_bus.req_val   = v;
        req_bus.req_we    = we;
        req_bus.req_addr  = a;
        req_bus.req_wdata = d;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        req_bus.req_val   = 1'b0;
        req_bus.req_we    = 1'b0;
        req_bus.req_addr  = '0;
        req_bus.req_wdata = '0;
        req_bus.rsp_rdy   = 1'b1;
        mem_bus.ready     = 1'b0;

        // Reset state
        #2;
        check("rst_req_rdy", req_bus.req_rdy, 0);
        check("rst_rsp_val", req_bus.rsp_val, 0);
        check("rst_mem_en", mem_bus.en, 0);
        check("rst_rsp_rdata", req_bus.rsp_rdata, 0);
        tick();
        rst = 1'b0;

        // 1. Init gating: pending read held off for 1024 cycles of memory init
        drive(1, 0, 10'h000, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (req_bus.req_rdy !== 1'b0 || mem_bus.en !== 1'b0) bad++;
            tick();
        end
        check("init_gate_violations", bad, 0);
        mem_bus.ready = 1'b1;
        #1;
        check("init_rdy_same_cycle", req_bus.req_rdy, 0);
        tick();
        check("init_rdy_next", req_bus.req_rdy, 1);
        check("init_accept_en", mem_bus.en, 1);
        check("init_accept_we", mem_bus.we, 0);
        tick();

        // 2. Write 0x005, read it back the next cycle, read unwritten 0x3FF
        drive(1, 1, 10'h005, 32'hDEADBEEF);
        check("init_rsp_val", req_bus.rsp_val, 1);
        check("init_rsp_data", req_bus.rsp_rdata, 32'h0);
        check("wr_en", mem_bus.en, 1);
        check("wr_we", mem_bus.we, 1);
        check("wr_addr", mem_bus.addr, 10'h005);
        check("wr_wdata", mem_bus.wdata, 32'hDEADBEEF);
        tick();
        drive(1, 0, 10'h005, 0);
        check("wr_no_rsp", req_bus.rsp_val, 0);
        check("rd_we", mem_bus.we, 0);
        check("rd_wdata_zero", mem_bus.wdata, 0);
        tick();
        drive(1, 0, 10'h3FF, 0);
        check("raw_rsp_val", req_bus.rsp_val, 1);
        check("raw_rsp_data", req_bus.rsp_rdata, 32'hDEADBEEF);
        check("raw_req_rdy", req_bus.req_rdy, 1);
        check("top_addr", mem_bus.addr, 10'h3FF);
        tick();
        drive(0, 0, 10'h000, 0);
        check("unwr_rsp_val", req_bus.rsp_val, 1);
        check("unwr_rsp_data", req_bus.rsp_rdata, 32'h0);
        check("idle_mem_en", mem_bus.en, 0);
        check("idle_mem_addr", mem_bus.addr, 0);
        tick();
        check("idle_rsp_val", req_bus.rsp_val, 0);

        // 3. Streaming: preload 16 words, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 10'h100 + 10'(i), 32'hC0DE0000 + 32'(i * 3));
            tick();
        end
        bad = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1, 0, 10'h100 + 10'(i), 0);
            else        drive(0, 0, 10'h000, 0);
            if (i < 16 && req_bus.req_rdy !== 1'b1) bad++;
            if (i > 0) begin
                check("stream_rsp_val", req_bus.rsp_val, 1);
                check("stream_rsp_data", req_bus.rsp_rdata, 32'hC0DE0000 + 32'((i - 1) * 3));
            end
            tick();
        end
        check("stream_rdy_drops", bad, 0);
        check("stream_done", req_bus.rsp_val, 0);

        // 4. Back-pressure: read 0x005, consumer stalls for 5 cycles
        drive(1, 0, 10'h005, 0);
        check("bp_accept", mem_bus.en, 1);
        tick();
        req_bus.rsp_rdy = 1'b0;
        drive(1, 0, 10'h3FF, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_bus.rsp_val !== 1'b1 || req_bus.rsp_rdata !== 32'hDEADBEEF ||
                req_bus.req_rdy !== 1'b0 || mem_bus.en !== 1'b0) bad++;
            tick();
        end
        check("bp_hold_violations", bad, 0);
        req_bus.rsp_rdy = 1'b1;
        #1;
        check("bp_release_val", req_bus.rsp_val, 1);
        check("bp_release_data", req_bus.rsp_rdata, 32'hDEADBEEF);
        check("bp_release_rdy", req_bus.req_rdy, 0);
        tick();
        check("bp_single_hs", req_bus.rsp_val, 0);
        check("bp_rdy_back", req_bus.req_rdy, 1);
        check("bp_next_accept", mem_bus.en, 1);
        tick();
        drive(0, 0, 10'h000, 0);
        check("bp_next_rsp", req_bus.rsp_val, 1);
        check("bp_next_data", req_bus.rsp_rdata, 32'h0);
        tick();

        // 5. Reset while a response is held
        drive(1, 0, 10'h005, 0);
        tick();
        req_bus.rsp_rdy = 1'b0;
        drive(0, 0, 10'h000, 0);
        tick();
        check("mid_held", req_bus.rsp_val, 1);
        rst = 1'b1;
        mem_bus.ready = 1'b0;
        #1;
        check("mid_rst_rsp_val", req_bus.rsp_val, 0);
        check("mid_rst_req_rdy", req_bus.req_rdy, 0);
        check("mid_rst_rdata", req_bus.rsp_rdata, 0);
        tick();
        tick();
        rst = 1'b0;
        req_bus.rsp_rdy = 1'b1;
        tick();
        mem_bus.ready = 1'b1;
        tick();
        check("post_rst_rdy", req_bus.req_rdy, 1);
        check("post_rst_no_rsp", req_bus.rsp_val, 0);
        tick();
        check("post_rst_no_rsp2", req_bus.rsp_val, 0);

        // 6. Memory ready drops with a read in flight
        drive(1, 0, 10'h005, 0);
        check("drop_accept", mem_bus.en, 1);
        mem_bus.ready = 1'b0;
        tick();
        check("drop_rsp_val", req_bus.rsp_val, 1);
        check("drop_rsp_data", req_bus.rsp_rdata, 32'hDEADBEEF);
        check("drop_req_rdy", req_bus.req_rdy, 0);
        check("drop_mem_en", mem_bus.en, 0);
        tick();
        check("drop_rsp_gone", req_bus.rsp_val, 0);
        check("drop_still_blocked", req_bus.req_rdy, 0);
        mem_bus.ready = 1'b1;
        tick();
        drive(1, 1, 10'h3FF, 32'h12345678);
        check("ready_back_rdy", req_bus.req_rdy, 1);
        check("ready_back_en", mem_bus.en, 1);
        tick();
        drive(1, 0, 10'h3FF, 0);
        tick();
        drive(0, 0, 10'h000, 0);
        check("top_rd_val", req_bus.rsp_val, 1);
        check("top_rd_data", req_bus.rsp_rdata, 32'h12345678);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
